// File: rtl/ps2_mouse_decoder_if.sv
// ps2_mouse_decoder_if
//   Bundles the raw PS/2 pins and the decoded mouse outputs. The decoder
//   connects through the master modport. The cursor/game logic that
//   consumes the packets connects through the slave modport.
//   ps2_clock, ps2_data : raw PS/2 pins, asynchronous to clock
//   mouse_clock         : packet strobe
//   mouse_button        : left button, 1 = pressed
//   mouse_delta_x       : signed X movement, positive = right
//   mouse_delta_y       : signed Y movement, positive = down
interface ps2_mouse_decoder_if;
    logic       ps2_clock;
    logic       ps2_data;
    logic       mouse_clock;
    logic       mouse_button;
    logic [8:0] mouse_delta_x;
    logic [8:0] mouse_delta_y;

    modport master (
        input  ps2_clock,
        input  ps2_data,
        output mouse_clock,
        output mouse_button,
        output mouse_delta_x,
        output mouse_delta_y
    );

    modport slave (
        output ps2_clock,
        output ps2_data,
        input  mouse_clock,
        input  mouse_button,
        input  mouse_delta_x,
        input  mouse_delta_y
    );
endinterface

// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder
//   Receive-only PS/2 mouse decoder. It assembles 11-bit device-to-host
//   frames into 3-byte movement packets and publishes the left button and
//   the screen-oriented signed 9-bit X/Y deltas, followed by a strobe.
//   Ports:
//     clock  : system clock. All logic runs on its rising edge.
//     reset  : synchronous, active-high reset.
//     bus    : ps2_mouse_decoder_if.master (PS/2 pins in, mouse outputs out)
//   Parameters:
//     TIMEOUT_CYCLES : idle cycles before a partial frame or packet is dropped
//     STROBE_CYCLES  : width of the mouse_clock pulse (>= 1)
//   Build option:
//     PS2_MOUSE_PARITY_EN : when defined, odd parity is checked in STOP.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (sample 0)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | parity bit slot
//   STOP   | stop bit; accept (1) or discard (0) the byte
module ps2_mouse_decoder #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int STROBE_CYCLES  = 2
) (
    input logic clock,
    input logic reset,
    ps2_mouse_decoder_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ST_W = $clog2(STROBE_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ST_W-1:0] STROBE_LAST = ST_W'(STROBE_CYCLES - 1);

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;
    logic sample;

    state_t          state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic [1:0]      pkt_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic       left_btn, x_sign, y_sign, x_ovf, y_ovf;
    logic [7:0] x_mag;

    logic            pub_pending;
    logic [ST_W-1:0] strobe_cnt;

    logic       strobe_q;
    logic       button_q;
    logic [8:0] dx_q;
    logic [8:0] dy_q;

    logic       parity_ok;
    logic [8:0] dx_next;
    logic [8:0] raw_y;
    logic [8:0] y_clamped;
    logic [8:0] dy_next;

    assign fall   = clk_prev & ~clk_s2;
    assign sample = dat_s2;

`ifdef PS2_MOUSE_PARITY_EN
    logic parity_bit;
    assign parity_ok = ^{shift_reg, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    // Deltas are formed from the stored byte 0/1 fields and the byte that is
    // sitting in the shift register when byte 2's stop bit arrives.
    always_comb begin
        dx_next   = x_ovf ? (x_sign ? 9'h100 : 9'h0FF) : {x_sign, x_mag};
        raw_y     = {y_sign, shift_reg};
        y_clamped = y_ovf ? (y_sign ? 9'h100 : 9'h0FF) : raw_y;
        // -(-256) does not fit in 9 bits, so it saturates to +255.
        dy_next   = (y_clamped == 9'h100) ? 9'h0FF : (9'd0 - y_clamped);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1      <= 1'b1;
            clk_s2      <= 1'b1;
            clk_prev    <= 1'b1;
            dat_s1      <= 1'b1;
            dat_s2      <= 1'b1;
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'd0;
            pkt_cnt     <= 2'd0;
            wd_cnt      <= '0;
            left_btn    <= 1'b0;
            x_sign      <= 1'b0;
            y_sign      <= 1'b0;
            x_ovf       <= 1'b0;
            y_ovf       <= 1'b0;
            x_mag       <= 8'd0;
            pub_pending <= 1'b0;
            strobe_cnt  <= '0;
            strobe_q    <= 1'b0;
            button_q    <= 1'b0;
            dx_q        <= 9'd0;
            dy_q        <= 9'd0;
`ifdef PS2_MOUSE_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            clk_s1   <= bus.ps2_clock;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= bus.ps2_data;
            dat_s2   <= dat_s1;

            // The strobe starts one cycle after the data update. A new
            // publication restarts the count.
            pub_pending <= 1'b0;
            if (pub_pending) begin
                strobe_q   <= 1'b1;
                strobe_cnt <= STROBE_LAST;
            end else if (strobe_q) begin
                if (strobe_cnt == '0)
                    strobe_q <= 1'b0;
                else
                    strobe_cnt <= strobe_cnt - ST_W'(1);
            end

            if (fall) begin
                // A falling edge takes priority over a coincident watchdog expiry.
                wd_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!sample) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {sample, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state   <= PARITY;
                            bit_cnt <= 3'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
`ifdef PS2_MOUSE_PARITY_EN
                        parity_bit <= sample;
`endif
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (sample && parity_ok) begin
                            case (pkt_cnt)
                                2'd0: begin
                                    // Bit 3 is always set in a header byte.
                                    // Without it, stay at 0 to resync.
                                    if (shift_reg[3]) begin
                                        left_btn <= shift_reg[0];
                                        x_sign   <= shift_reg[4];
                                        y_sign   <= shift_reg[5];
                                        x_ovf    <= shift_reg[6];
                                        y_ovf    <= shift_reg[7];
                                        pkt_cnt  <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    x_mag   <= shift_reg;
                                    pkt_cnt <= 2'd2;
                                end
                                default: begin
                                    button_q    <= left_btn;
                                    dx_q        <= dx_next;
                                    dy_q        <= dy_next;
                                    pub_pending <= 1'b1;
                                    pkt_cnt     <= 2'd0;
                                end
                            endcase
                        end else begin
                            pkt_cnt <= 2'd0;
                        end
                    end
                endcase
            end else if (state != IDLE || pkt_cnt != 2'd0) begin
                if (wd_cnt == WD_LAST) begin
                    wd_cnt  <= '0;
                    state   <= IDLE;
                    bit_cnt <= 3'd0;
                    pkt_cnt <= 2'd0;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign bus.mouse_clock   = strobe_q;
    assign bus.mouse_button  = button_q;
    assign bus.mouse_delta_x = dx_q;
    assign bus.mouse_delta_y = dy_q;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// tb_ps2_mouse_decoder
//   Directed testbench for ps2_mouse_decoder. PS/2 frames are generated at a
//   slow bit rate. A negedge monitor counts strobes and records their width
//   and the data-to-strobe lead.
module tb_ps2_mouse_decoder;

    localparam int HALF = 10;

    logic clock;
    logic reset;
    ps2_mouse_decoder_if bus();

    ps2_mouse_decoder #(
        .TIMEOUT_CYCLES(10000),
        .STROBE_CYCLES (2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int         cyc          = 0;
    int         strobe_count = 0;
    int         rise_cyc     = 0;
    int         change_cyc   = 0;
    int         last_width   = 0;
    int         last_lead    = 0;
    logic       prev_mc      = 1'b0;
    logic [18:0] prev_data   = '0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if ({bus.mouse_button, bus.mouse_delta_x, bus.mouse_delta_y} !== prev_data)
            change_cyc = cyc;
        if (bus.mouse_clock === 1'b1 && prev_mc !== 1'b1) begin
            strobe_count = strobe_count + 1;
            rise_cyc     = cyc;
            last_lead    = rise_cyc - change_cyc;
        end
        if (prev_mc === 1'b1 && bus.mouse_clock !== 1'b1)
            last_width = cyc - rise_cyc;
        prev_mc   = bus.mouse_clock;
        prev_data = {bus.mouse_button, bus.mouse_delta_x, bus.mouse_delta_y};
    end

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.ps2_data = f[i];
            repeat (HALF) @(negedge clock);
            bus.ps2_clock = 1'b0;
            repeat (HALF) @(negedge clock);
            bus.ps2_clock = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(f, 11);
    endtask

    task automatic check_outputs(input string name, input logic btn,
                                 input logic [8:0] dx, input logic [8:0] dy);
        checks++;
        if (bus.mouse_button !== btn) begin
            errors++;
            $display("FAIL %s button got %b want %b", name, bus.mouse_button, btn);
        end
        checks++;
        if (bus.mouse_delta_x !== dx) begin
            errors++;
            $display("FAIL %s dx got %h want %h", name, bus.mouse_delta_x, dx);
        end
        checks++;
        if (bus.mouse_delta_y !== dy) begin
            errors++;
            $display("FAIL %s dy got %h want %h", name, bus.mouse_delta_y, dy);
        end
    endtask

    task automatic check_strobes(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s strobes got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clock);
        checks++;
        if (bus.mouse_clock !== 1'b0) begin
            errors++;
            $display("FAIL reset mouse_clock got %b want 0", bus.mouse_clock);
        end
        check_outputs("reset", 1'b0, 9'h000, 9'h000);
        check_strobes("reset", strobe_count, 0);
    endtask

    task automatic test_basic_packet();
        int s0;
        s0 = strobe_count;
        send_byte(8'h39, 0);
        send_byte(8'hFE, 0);
        send_byte(8'hFB, 0);
        repeat (20) @(negedge clock);
        check_strobes("basic", strobe_count - s0, 1);
        check_outputs("basic", 1'b1, 9'h1FE, 9'h005);
        checks++;
        if (last_width !== 2) begin
            errors++;
            $display("FAIL basic strobe width got %0d want 2", last_width);
        end
        checks++;
        if (last_lead !== 1) begin
            errors++;
            $display("FAIL basic data lead got %0d want 1", last_lead);
        end
    endtask

    task automatic test_y_saturate();
        int s0;
        s0 = strobe_count;
        send_byte(8'h28, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (20) @(negedge clock);
        check_strobes("ysat", strobe_count - s0, 1);
        check_outputs("ysat", 1'b0, 9'h000, 9'h0FF);
    endtask

    task automatic test_x_overflow();
        int s0;
        s0 = strobe_count;
        send_byte(8'h48, 0);
        send_byte(8'h10, 0);
        send_byte(8'h03, 0);
        repeat (20) @(negedge clock);
        check_strobes("xovf", strobe_count - s0, 1);
        check_outputs("xovf", 1'b0, 9'h0FF, 9'h1FD);
    endtask

    task automatic test_resync();
        int s0;
        s0 = strobe_count;
        send_byte(8'h01, 0);
        send_byte(8'h08, 0);
        send_byte(8'h04, 0);
        send_byte(8'h02, 0);
        repeat (20) @(negedge clock);
        check_strobes("resync", strobe_count - s0, 1);
        check_outputs("resync", 1'b0, 9'h004, 9'h1FE);
    endtask

    task automatic test_watchdog();
        int s0;
        s0 = strobe_count;
        send_byte(8'h08, 0);
        send_byte(8'h01, 0);
        repeat (10001) @(negedge clock);
        check_strobes("wdog_partial", strobe_count - s0, 0);
        send_byte(8'h09, 0);
        send_byte(8'h07, 0);
        send_byte(8'h00, 0);
        repeat (20) @(negedge clock);
        check_strobes("wdog", strobe_count - s0, 1);
        check_outputs("wdog", 1'b1, 9'h007, 9'h000);
    endtask

    task automatic test_parity();
        int s0;
        int want;
`ifdef PS2_MOUSE_PARITY_EN
        want = 1;
`else
        want = 2;
`endif
        s0 = strobe_count;
        send_byte(8'h08, 0);
        send_byte(8'h05, 1);
        send_byte(8'h03, 0);
        send_byte(8'h09, 0);
        send_byte(8'h02, 0);
        send_byte(8'h02, 0);
        repeat (20) @(negedge clock);
        check_strobes("parity", strobe_count - s0, want);
        check_outputs("parity", 1'b1, 9'h002, 9'h1FE);
    endtask

    task automatic test_reset_mid_byte();
        int s0;
        logic [10:0] f;
        s0 = strobe_count;
        send_byte(8'h08, 0);
        f = {1'b1, 1'b0, 8'h5A, 1'b0};
        send_bits(f, 4);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.mouse_clock !== 1'b0) begin
            errors++;
            $display("FAIL midreset mouse_clock got %b want 0", bus.mouse_clock);
        end
        check_outputs("midreset", 1'b0, 9'h000, 9'h000);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (50) @(negedge clock);
        check_strobes("midreset_idle", strobe_count - s0, 0);
        check_outputs("midreset_idle", 1'b0, 9'h000, 9'h000);
        send_byte(8'h18, 0);
        send_byte(8'h80, 0);
        send_byte(8'h01, 0);
        repeat (20) @(negedge clock);
        check_strobes("after_reset", strobe_count - s0, 1);
        check_outputs("after_reset", 1'b0, 9'h180, 9'h1FF);
    endtask

    initial begin
        reset         = 1'b1;
        bus.ps2_clock = 1'b1;
        bus.ps2_data  = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_basic_packet();
        test_y_saturate();
        test_x_overflow();
        test_resync();
        test_watchdog();
        test_parity();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_decoder.md
# ps2_mouse_decoder

Receives the PS/2 mouse serial stream, assembles 11-bit device-to-host frames into standard 3-byte movement packets, and presents left-button state and signed 9-bit screen-oriented X/Y deltas with a packet strobe. It sits between the board PS/2 pins and the game/cursor logic, and drives that logic's `mouse_clock`, `mouse_button`, `mouse_delta_x` and `mouse_delta_y` inputs. Receive-only: no host-to-device commands.

## Interface
- `TIMEOUT_CYCLES`, 10000: clock cycles without a PS/2 falling edge before a partial frame or packet is discarded (200 us at 50 MHz).
- `STROBE_CYCLES`, 2: width of the `mouse_clock` high pulse, in clock cycles; must be ≥1.
- `clock` input 1: system clock. One clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `ps2_clock` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `mouse_clock` output 1: packet strobe. High for `STROBE_CYCLES` cycles per accepted packet.
- `mouse_button` output 1: left button, 1 = pressed.
- `mouse_delta_x` output 9: signed X movement, positive = right.
- `mouse_delta_y` output 9: signed Y movement, positive = down (screen convention).

## Operation
- Both pins pass through 2-flop synchronizers. A falling edge is detected on the synchronized clock (previous 1, current 0). Data is sampled on the cycle the edge is detected.
- Frame FSM:
  - IDLE: sample must be 0 (start) → DATA. A sample of 1 stays in IDLE.
  - DATA: 8 samples, LSB first, into a shift register → PARITY.
  - PARITY: store the sample → STOP.
  - STOP: sample 1 → byte accepted; sample 0 → byte discarded and packet counter cleared. Both exits → IDLE.
- Packet counter 0..2 holds accepted bytes:
  - Byte 0 is accepted only if bit3 = 1. Otherwise it is discarded and the counter stays 0 (resync).
  - Byte 0 fields: bit0 left, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow. Byte 1 = X magnitude, byte 2 = Y magnitude.
  - On byte 2 acceptance, the counter returns to 0 and the packet is published.
- Arithmetic:
  - raw_x = {xsign, byte1}; raw_y = {ysign, byte2} (9-bit two's complement).
  - X overflow set → dx = xsign ? 9'h100 : 9'h0FF; else dx = raw_x.
  - Y overflow set → raw_y clamped to 9'h100 / 9'h0FF by ysign before negation.
  - dy = −raw_y, except raw_y = 9'h100 (−256) → dy = 9'h0FF (+255, saturated).
- Watchdog counter:
  - Cleared on every falling edge. Counts while in a non-IDLE state or while the packet counter ≠ 0.
  - On reaching `TIMEOUT_CYCLES`: FSM → IDLE, bit and packet counters cleared. Outputs are untouched.
- Outputs hold their last published values between packets.

## Timing
- Reset: `mouse_clock`=0, `mouse_button`=0, `mouse_delta_x`=0, `mouse_delta_y`=0. FSM is IDLE, and all counters and the watchdog are 0. Reset asserted mid-frame or mid-packet discards the partial data. No strobe is generated for a discarded packet.
- Let N be the cycle on which the stop-bit falling edge of byte 2 is detected:
  - N+1: `mouse_button` and the deltas update.
  - N+2: `mouse_clock` rises and stays high through N+1+`STROBE_CYCLES`.
  - Data is therefore stable one cycle before the rising strobe edge and is held until the next publication.
- Pin-to-detect latency is 2–3 cycles from the synchronizers.
- A new packet completing while the strobe is still high is not possible at PS/2 rates, so no queuing is required. If it does occur, the newer data overwrites the outputs and the strobe restarts its count.
- A watchdog expiry in the same cycle as a falling edge: the edge takes priority.

## Configuration
- `PS2_MOUSE_PARITY_EN` defined: in STOP, a byte is discarded (and the packet counter cleared) if the XOR of its 8 data bits and the parity bit is not 1 (odd parity).
- Macro undefined: the parity bit is sampled and ignored. The parity-check logic is not synthesized.

## Test plan
- Frames 0x29, 0xFE... correction not needed; frames 0x39, 0xFE, 0xFB with valid parity and stop bits → one strobe, `mouse_button`=1, `mouse_delta_x`=9'h1FE (−2), `mouse_delta_y`=9'h005 (+5), strobe high exactly 2 cycles.
- Frames 0x28, 0x00, 0x00 → `mouse_button`=0, dx=9'h000, dy=9'h0FF (saturated from −256).
- Frames 0x48, 0x10, 0x03 (X overflow, positive) → dx=9'h0FF, dy=9'h1FD (−3).
- Frame 0x01 (bit3=0), then 0x08, 0x04, 0x02 → exactly one strobe, with dx=9'h004 and dy=9'h1FE.
- Frames 0x08, 0x01, then idle 10001 cycles, then 0x09, 0x07, 0x00 → exactly one strobe, with button=1, dx=9'h007, dy=9'h000.
- With `PS2_MOUSE_PARITY_EN`: byte 1 sent with wrong parity inside a 3-byte packet, then a valid packet → only the valid packet is strobed. Without the macro, the first packet is also strobed. Separately, asserting `reset` mid-byte → all outputs read 0 on the next cycle and no strobe is produced.
